alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 14 +
 rtl/alu_seq.sv | 73 +++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and sequencer state encoding shared by alu_seq
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOTA = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd8;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;
endpackage

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external registered-operand ALU datapath
// ALU_SEQ_OPCHK_EN: opcodes above OP_MAX bypass the datapath and respond with rsp_err
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       dp_inA,
  output logic [7:0]       dp_inB,
  output logic             dp_s,
  output logic [3:0]       dp_op,
  input  logic [8:0]       dp_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [8:0]       rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] txn_cnt
);
  state_t state, state_nx;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic err_q, accept, bad_op, dp_act;
`ifdef ALU_SEQ_OPCHK_EN
  assign bad_op = cmd_op > OP_MAX;
`else
  assign bad_op = 1'b0;
`endif
  assign accept = cmd_valid && cmd_ready;
  always_comb begin
    state_nx  = state;
    state_nx  = state == IDLE   ? (accept ? (bad_op ? RESP : DRIVE) : IDLE) :
                state == DRIVE  ? SAMPLE :
                state == SAMPLE ? RESP :
                rsp_ready       ? IDLE : RESP;
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
    dp_act    = state == DRIVE || state == SAMPLE;
    dp_s      = dp_act;
    dp_inA    = dp_act ? a_q : '0;
    dp_inB    = dp_act ? b_q : '0;
    dp_op     = dp_act ? op_q : '0;
    rsp_err   = err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      rsp_data <= '0;
      txn_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= cmd_op;
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        err_q <= bad_op;
      end
      if (accept && bad_op) rsp_data <= '0;
      if (state == SAMPLE) rsp_data <= dp_y;
      if (rsp_valid && rsp_ready && !(&txn_cnt)) txn_cnt <= txn_cnt + 1'b1;
    end
  end
endmodule
